// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - add/subtract sequencer that time-shares one external 8-bit adder
// Subtraction support is built only when CALC_SEQ_SUB_EN is defined.
module calc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op_sub,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [8:0] add_y,
  output logic       busy,
  output logic       done,
  output logic [8:0] result,
  output logic       neg
);

  typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [8:0] result_q;

`ifdef CALC_SEQ_SUB_EN
  logic       rop;
  logic [8:0] s1;
  logic [7:0] s2;
  logic       neg_q;
  logic       carry;

  // A-B is formed as A + ~B + 1; a carry out of either step means A >= B.
  assign carry = s1[8] | add_y[8];
  assign neg   = neg_q;
`else
  logic       unused_op_sub;

  assign unused_op_sub = op_sub;
  assign neg           = 1'b0;
`endif

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_q;

  always_comb begin
    state_nxt = state;
    add_a     = 8'h00;
    add_b     = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_nxt = P1;
      end
      P1: begin
        add_a = ra;
`ifdef CALC_SEQ_SUB_EN
        add_b     = rop ? ~rb : rb;
        state_nxt = rop ? P2 : DONE;
`else
        add_b     = rb;
        state_nxt = DONE;
`endif
      end
`ifdef CALC_SEQ_SUB_EN
      P2: begin
        add_a     = s1[7:0];
        add_b     = 8'h01;
        state_nxt = carry ? DONE : P3;
      end
      P3: begin
        // Negative difference: two's-complement negate the raw sum.
        add_a     = ~s2;
        add_b     = 8'h01;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ra       <= 8'h00;
      rb       <= 8'h00;
      result_q <= 9'h000;
`ifdef CALC_SEQ_SUB_EN
      rop      <= 1'b0;
      s1       <= 9'h000;
      s2       <= 8'h00;
      neg_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= opa;
            rb  <= opb;
`ifdef CALC_SEQ_SUB_EN
            rop <= op_sub;
`endif
          end
        end
        P1: begin
`ifdef CALC_SEQ_SUB_EN
          s1 <= add_y;
          if (!rop) begin
            result_q <= add_y;
            neg_q    <= 1'b0;
          end
`else
          result_q <= add_y;
`endif
        end
`ifdef CALC_SEQ_SUB_EN
        P2: begin
          s2 <= add_y[7:0];
          if (carry) begin
            result_q <= {1'b0, add_y[7:0]};
            neg_q    <= 1'b0;
          end
        end
        P3: begin
          result_q <= {1'b0, add_y[7:0]};
          neg_q    <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Port list SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin an operation
- op_sub  in  1  operation select, sampled with start: 0 = A+B, 1 = A-B
- opa  in  8  operand A, unsigned, sampled with start
- opb  in  8  operand B, unsigned, sampled with start
- add_a  out  8  operand A to the shared 8-bit ripple-carry adder (carry-in fixed 0)
- add_b  out  8  operand B to the shared adder
- add_y  in  9  adder sum {cout, sum[7:0]}, combinational from add_a/add_b
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when the result becomes valid
- result  out  9  held magnitude of the last result
- neg  out  1  result is negative; subtraction only

Function
REQ-003 FSM states SHALL be IDLE, P1, P2, P3 and DONE.
REQ-004 In IDLE with start=1, the block SHALL latch opa, opb and op_sub into internal ra, rb and rop, then enter P1.
REQ-005 start SHALL be ignored in every state other than IDLE, with no re-latch and no queuing.
REQ-006 Adder operands SHALL be combinational from state and internal registers:
- IDLE, DONE: add_a = 0, add_b = 0
- P1: add_a = ra; add_b = rop ? ~rb : rb
- P2: add_a = s1[7:0]; add_b = 8'h01
- P3: add_a = ~s2[7:0]; add_b = 8'h01
REQ-007 In P1, add_y SHALL be captured into s1 at the clock edge.
- rop=0: result <= add_y, neg <= 0, go to DONE.
- rop=1: go to P2.
REQ-008 In P2, s2 <= add_y[7:0] and c = s1[8] | add_y[8].
- c=1: result <= {1'b0, add_y[7:0]}, neg <= 0, go to DONE.
- c=0: go to P3.
REQ-009 In P3, result <= {1'b0, add_y[7:0]} and neg <= 1, then go to DONE.
REQ-010 In DONE, done SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-011 done latency, counted from the edge that samples start, SHALL be:
- add: 2 cycles
- subtract with A>=B: 3 cycles
- subtract with A<B: 4 cycles
REQ-012 result and neg SHALL hold their value until the next DONE or rst, and SHALL be stable while busy.
REQ-013 A+B SHALL return the full 9-bit sum without overflow. A-B SHALL return |A-B| in result[7:0], with result[8] = 0.

Reset
REQ-014 rst SHALL force IDLE and clear to 0: result, neg, done, busy, add_a, add_b, ra, rb, rop, s1, s2.
REQ-015 rst asserted mid-operation SHALL abort it, with no done pulse.
REQ-016 When rst and start coincide, rst SHALL win and start SHALL be lost.

Configuration
REQ-017 Macro CALC_SEQ_SUB_EN SHALL select subtraction support.
- Defined: behaviour as in REQ-006 to REQ-009.
- Undefined: op_sub is ignored (treated as 0), P2 and P3 are not implemented, neg is tied 0, and every start performs A+B.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- start, op_sub=0, opa=200, opb=100 -> done 2 cycles later; result=300, neg=0.
- start, op_sub=0, opa=255, opb=255 -> result=0x1FE, neg=0.
- start, op_sub=1, opa=7, opb=5 -> done after 3 cycles; result=2, neg=0.
- start, op_sub=1, opa=5, opb=7 -> done after 4 cycles; result=2, neg=1.
- start, op_sub=1, opa=0, opb=0 -> result=0, neg=0.
- start during P2, then rst in P3 -> second start ignored; no done; all outputs 0 the next cycle.
